// File: rtl/compare_window_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : compare_window_counter_pkg
//  Description : Shared FSM state encoding and operand-width helpers for the
//                compare window counter and its cascaded comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
package compare_window_counter_pkg;

    // Operands are compared in slices of this many bits
    localparam int unsigned c_slice_w = 4;

    // Window control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cwc_state_t;

    // True when an operand width can be split into whole comparator slices
    function automatic bit cwc_width_ok(input int unsigned m);
        return (m >= c_slice_w) && ((m % c_slice_w) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/compare_window_counter_cascade_four_bit_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : cascade_four_bit_comparator
//  Description : Unsigned magnitude comparator built from 4-bit slices that
//                cascade from the most significant slice downward, in the
//                manner of chained 7485 parts. Exactly one flag is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module cascade_four_bit_comparator
    import compare_window_counter_pkg::*;
#(
    parameter int unsigned M = 4
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         aEQb,
    output logic         aLTb,
    output logic         aGTb
);

    localparam int unsigned c_num_slices = M / c_slice_w;

    // Reject widths that do not split into whole slices
    if (!cwc_width_ok(M)) begin : g_bad_width
        $error("cascade_four_bit_comparator: M must be a non-zero multiple of 4");
    end

    // Per-slice local compare results, independent of the cascade
    logic [c_num_slices-1:0] w_nib_eq;
    logic [c_num_slices-1:0] w_nib_lt;
    logic [c_num_slices-1:0] w_nib_gt;

    for (genvar gi = 0; gi < c_num_slices; gi++) begin : g_slice
        logic [c_slice_w-1:0] w_a_nib;
        logic [c_slice_w-1:0] w_b_nib;

        assign w_a_nib      = a[gi*c_slice_w +: c_slice_w];
        assign w_b_nib      = b[gi*c_slice_w +: c_slice_w];
        assign w_nib_eq[gi] = (w_a_nib == w_b_nib);
        assign w_nib_lt[gi] = (w_a_nib <  w_b_nib);
        assign w_nib_gt[gi] = (w_a_nib >  w_b_nib);
    end

    logic w_eq;
    logic w_lt;
    logic w_gt;

    // Cascade: a lower slice only decides when every higher slice was equal
    always_comb begin
        w_eq = 1'b1;
        w_lt = 1'b0;
        w_gt = 1'b0;
        for (int i = c_num_slices - 1; i >= 0; i--) begin
            w_lt = w_lt | (w_eq & w_nib_lt[i]);
            w_gt = w_gt | (w_eq & w_nib_gt[i]);
            w_eq = w_eq & w_nib_eq[i];
        end
    end

    assign aEQb = w_eq;
    assign aLTb = w_lt;
    assign aGTb = w_gt;

endmodule
`default_nettype wire

// File: rtl/compare_window_counter.sv
`default_nettype none
// ============================================================================
//  Module      : compare_window_counter
//  Description : Accepts a window of win_len operand pairs and counts how many
//                had a==b, a<b and a>b, while tracking the largest operand
//                seen. Pulses done for one cycle when the window closes; the
//                results then hold until the next accepted start.
//  Revision    : 1.0 - initial release
// ============================================================================
module compare_window_counter
    import compare_window_counter_pkg::*;
#(
    parameter int unsigned M = 4,
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] win_len,
    input  logic         in_valid,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         in_ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] eq_cnt,
    output logic [W-1:0] lt_cnt,
    output logic [W-1:0] gt_cnt,
    output logic [M-1:0] max_val
);

    // Reject operand widths that the sliced comparator cannot handle
    if (!cwc_width_ok(M)) begin : g_bad_width
        $error("compare_window_counter: M must be a non-zero multiple of 4");
    end

    cwc_state_t   r_state;
    logic         r_busy;
    logic         r_done;
    logic [W-1:0] r_remaining;
    logic [W-1:0] r_eq_cnt;
    logic [W-1:0] r_lt_cnt;
    logic [W-1:0] r_gt_cnt;
    logic [M-1:0] r_max;

    logic         w_aeqb;
    logic         w_altb;
    logic         w_agtb;
    logic         w_accept_start;
    logic         w_xfer;
    logic         w_last_xfer;
    logic [M-1:0] w_pair_max;
    logic [M-1:0] w_max_next;

    // The single compare source for both counting and the max tracker
    cascade_four_bit_comparator #(
        .M (M)
    ) u_cmp (
        .a    (a),
        .b    (b),
        .aEQb (w_aeqb),
        .aLTb (w_altb),
        .aGTb (w_agtb)
    );

    assign in_ready       = (r_state == RUN);
    assign w_accept_start = (r_state == IDLE) & start;
    assign w_xfer         = in_valid & in_ready;
    assign w_last_xfer    = w_xfer & (r_remaining == W'(1));

    // Larger of the pair comes from the shared comparator; only the
    // comparison against the running maximum needs its own magnitude check
    assign w_pair_max = w_agtb ? a : b;
    assign w_max_next = (w_pair_max > r_max) ? w_pair_max : r_max;

    // Window control FSM with registered busy/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept_start) begin
                        r_busy <= 1'b1;
                        if (win_len == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_last_xfer) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Remaining-pair counter: loaded on start, decremented per transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= '0;
        end else if (w_accept_start) begin
            r_remaining <= win_len;
        end else if (w_xfer) begin
            r_remaining <= r_remaining - W'(1);
        end
    end

    // Result counters: cleared on start, one bucket bumped per transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eq_cnt <= '0;
            r_lt_cnt <= '0;
            r_gt_cnt <= '0;
        end else if (w_accept_start) begin
            r_eq_cnt <= '0;
            r_lt_cnt <= '0;
            r_gt_cnt <= '0;
        end else if (w_xfer) begin
            if (w_aeqb) begin
                r_eq_cnt <= r_eq_cnt + W'(1);
            end else if (w_altb) begin
                r_lt_cnt <= r_lt_cnt + W'(1);
            end else if (w_agtb) begin
                r_gt_cnt <= r_gt_cnt + W'(1);
            end
        end
    end

    // Running maximum of every accepted operand in the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max <= '0;
        end else if (w_accept_start) begin
            r_max <= '0;
        end else if (w_xfer) begin
            r_max <= w_max_next;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign eq_cnt  = r_eq_cnt;
    assign lt_cnt  = r_lt_cnt;
    assign gt_cnt  = r_gt_cnt;
    assign max_val = r_max;

endmodule
`default_nettype wire

// File: tb/tb_compare_window_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_compare_window_counter
//  Description : Self-checking bench for compare_window_counter. A window-level
//                reference model tracks counts, maximum and the window phase;
//                every cycle the DUT outputs are compared against it.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_compare_window_counter;

    localparam int unsigned M = 12;
    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] win_len;
    logic         in_valid;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic         in_ready;
    logic         busy;
    logic         done;
    logic [W-1:0] eq_cnt;
    logic [W-1:0] lt_cnt;
    logic [W-1:0] gt_cnt;
    logic [M-1:0] max_val;

    compare_window_counter #(.M(M), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .win_len  (win_len),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .eq_cnt   (eq_cnt),
        .lt_cnt   (lt_cnt),
        .gt_cnt   (gt_cnt),
        .max_val  (max_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_cycles = 0;

    // Reference model: phase 0 = idle, 1 = collecting pairs, 2 = closing cycle
    int m_phase = 0;
    int m_eq    = 0;
    int m_lt    = 0;
    int m_gt    = 0;
    int m_max   = 0;
    int m_left  = 0;
    int m_len   = 0;
    int m_starts = 0;
    int m_dones  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_eq = 0; m_lt = 0; m_gt = 0; m_max = 0; m_left = 0; m_len = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_step();
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        if (!rst_n) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (start) begin
                m_eq = 0; m_lt = 0; m_gt = 0; m_max = 0;
                m_len  = int'(win_len);
                m_left = int'(win_len);
                m_phase = (m_left == 0) ? 2 : 1;
                m_starts++;
            end
        end else if (m_phase == 1) begin
            if (in_valid) begin
                if (ai == bi)      m_eq++;
                else if (ai < bi)  m_lt++;
                else               m_gt++;
                if (ai > m_max) m_max = ai;
                if (bi > m_max) m_max = bi;
                m_left--;
                if (m_left == 0) m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
        if (m_phase == 2) m_dones++;
    endtask

    task automatic compare_all();
        chk("in_ready", 32'(in_ready), 32'(m_phase == 1));
        chk("busy",     32'(busy),     32'(m_phase != 0));
        chk("done",     32'(done),     32'(m_phase == 2));
        chk("eq_cnt",   32'(eq_cnt),   32'(m_eq));
        chk("lt_cnt",   32'(lt_cnt),   32'(m_lt));
        chk("gt_cnt",   32'(gt_cnt),   32'(m_gt));
        chk("max_val",  32'(max_val),  32'(m_max));
        chk("sum_le_len", 32'((int'(eq_cnt) + int'(lt_cnt) + int'(gt_cnt)) <= m_len), 32'(1));
    endtask

    // One clock: model follows the rising edge, outputs checked on the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        n_cycles++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic pair(input bit v, input int av, input int bv);
        in_valid = v;
        a = M'(av);
        b = M'(bv);
        tick();
    endtask

    initial begin
        int done_seen;
        int win_goal;
        rst_n = 1'b0; start = 1'b0; win_len = '0; in_valid = 1'b0; a = '0; b = '0;
        model_reset();

        // Reset state
        tick();
        tick();
        chk("reset_eq", 32'(eq_cnt), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // Three-pair window: one of each relation, max 200
        start = 1'b1; win_len = 8'd3; tick();
        start = 1'b0;
        pair(1, 5, 5);
        pair(1, 3, 9);
        pair(1, 200, 7);
        chk("w3_done", 32'(done), 32'd1);
        chk("w3_eq", 32'(eq_cnt), 32'd1);
        chk("w3_lt", 32'(lt_cnt), 32'd1);
        chk("w3_gt", 32'(gt_cnt), 32'd1);
        chk("w3_max", 32'(max_val), 32'd200);
        pair(0, 0, 0);
        chk("w3_done_cleared", 32'(done), 32'd0);

        // Empty window closes immediately with zeroed results
        start = 1'b1; win_len = 8'd0; tick();
        start = 1'b0;
        chk("w0_done", 32'(done), 32'd1);
        chk("w0_max", 32'(max_val), 32'd0);
        tick();
        chk("w0_idle_busy", 32'(busy), 32'd0);

        // Two pairs separated by a three-cycle in_valid gap
        start = 1'b1; win_len = 8'd2; tick();
        start = 1'b0;
        pair(1, 1, 2);
        pair(0, 9, 3);
        pair(0, 0, 7);
        pair(0, 4, 4);
        chk("gap_lt_held", 32'(lt_cnt), 32'd1);
        pair(1, 2, 1);
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_gt", 32'(gt_cnt), 32'd1);
        pair(0, 0, 0);

        // Asynchronous reset after one transfer of a four-pair window
        start = 1'b1; win_len = 8'd4; tick();
        start = 1'b0;
        pair(1, 300, 17);
        pair(0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        chk("async_gt", 32'(gt_cnt), 32'd0);
        chk("async_max", 32'(max_val), 32'd0);
        model_reset();
        tick();
        rst_n = 1'b1;
        pair(1, 1, 1);
        pair(1, 1, 1);
        start = 1'b1; win_len = 8'd1; in_valid = 1'b0; tick();
        start = 1'b0;
        pair(1, 4095, 0);
        chk("post_reset_max", 32'(max_val), 32'd4095);
        pair(0, 0, 0);

        // start held high: back-to-back single-pair windows every three cycles
        done_seen = 0;
        start = 1'b1; win_len = 8'd1;
        for (int i = 0; i < 9; i++) begin
            pair(1, 0, 255);
            if (done) done_seen++;
        end
        chk("repeat_done_count", 32'(done_seen), 32'd3);
        chk("repeat_lt", 32'(lt_cnt), 32'd1);
        chk("repeat_max", 32'(max_val), 32'd255);
        start = 1'b0;
        pair(0, 0, 0);

        // Full-length window: 255 equal pairs, counter must not wrap
        start = 1'b1; win_len = 8'd255; tick();
        start = 1'b0;
        for (int i = 0; i < 255; i++) pair(1, 7, 7);
        chk("full_eq", 32'(eq_cnt), 32'd255);
        pair(0, 0, 0);

        // Randomized windows
        win_goal = m_starts + 1000;
        while (m_starts < win_goal && n_cycles < 60000) begin
            int r;
            start = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 19));
            win_len = (r == 0) ? 8'd0 : W'($urandom_range(1, 8));
            in_valid = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 5))
                0: a = '0;
                1: a = '1;
                default: a = M'($urandom);
            endcase
            b = ($urandom_range(0, 3) == 0) ? a : M'($urandom);
            tick();
        end
        chk("random_window_budget", 32'(m_starts >= win_goal), 32'd1);

        // Drain any open window, bounded
        start = 1'b0;
        for (int i = 0; i < 20 && m_phase != 0; i++) pair(1, 0, 0);
        chk("drain_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/compare_window_counter.md
COMPARE_WINDOW_COUNTER -- requirements
Module: compare_window_counter

Interface
REQ-001 Parameter M, default 4, operand width in bits; SHALL be a multiple of 4, minimum 4.
REQ-002 Parameter W, default 8, width of window length and count outputs.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  begin a new window; sampled only in IDLE.
REQ-006 win_len  input  W  number of operand pairs in the window; sampled with start.
REQ-007 in_valid  input  1  a/b pair present.
REQ-008 a  input  M  operand A, unsigned.
REQ-009 b  input  M  operand B, unsigned.
REQ-010 in_ready  output  1  block accepts a pair this cycle.
REQ-011 busy  output  1  high in RUN and DONE.
REQ-012 done  output  1  one-cycle pulse; window complete.
REQ-013 eq_cnt / lt_cnt / gt_cnt  output  W each  counts of a==b, a<b, a>b in current window.
REQ-014 max_val  output  M  largest of all a and b accepted in current window.

Function
REQ-015 FSM states IDLE, RUN, DONE; in_ready SHALL equal (state==RUN), combinational from state only.
REQ-016 IDLE: start=1 SHALL clear all counts and max_val to 0, load remaining<=win_len, go RUN; if win_len==0, go DONE instead.
REQ-017 start SHALL be ignored in RUN and DONE.
REQ-018 Transfer = in_valid & in_ready; only transfers update state; in_valid while in_ready=0 SHALL be ignored (no buffering).
REQ-019 Per transfer, exactly one of eq_cnt, lt_cnt, gt_cnt SHALL increment by 1, chosen by the comparator flags aEQb/aLTb/aGTb for that a,b.
REQ-020 Per transfer, max_val SHALL become max(max_val, a, b), unsigned.
REQ-021 Latency: counts and max_val reflect a transfer in the cycle after it (registered outputs).
REQ-022 remaining SHALL decrement per transfer; transfer with remaining==1 SHALL move FSM to DONE.
REQ-023 DONE lasts exactly one cycle with done=1, then IDLE; counts and max_val SHALL hold until next accepted start.
REQ-024 Invariant: eq_cnt+lt_cnt+gt_cnt == pairs accepted in window <= win_len; no counter wraps.
REQ-025 in_valid gaps in RUN SHALL stall the window indefinitely without state change.
REQ-026 start in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, in_ready=0, busy=0, done=0, all counts=0, max_val=0, remaining=0.
REQ-028 Reset mid-window SHALL discard the window; no done pulse follows deassertion.
REQ-029 Deassertion is synchronised externally; block requires no reset-release logic.

Structure
REQ-030 Shared package SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the M%4==0 check constant.
REQ-031 One sub-module: cascade_four_bit_comparator (parameter M) instantiated once on a,b; its aEQb/aLTb/aGTb SHALL be the only compare source.
REQ-032 Max update SHALL reuse flag aGTb for max(a,b) plus one local M-bit compare against max_val.

Verification
REQ-033 M=8,W=8: start, win_len=3; pairs (5,5),(3,9),(200,7) -> done pulse after third transfer; eq=1, lt=1, gt=1, max_val=200.
REQ-034 win_len=0 start -> DONE next cycle, done=1 for one cycle, all counts 0, max_val 0, in_ready never 1.
REQ-035 win_len=2, in_valid high only on cycles 1 and 5 of RUN with (1,2),(2,1) -> done one cycle after cycle 5; lt=1, gt=1; counts unchanged during gap.
REQ-036 rst_n low for 1 cycle after one of 4 transfers -> outputs all 0 asynchronously, FSM IDLE, no done; new start works normally.
REQ-037 start held high continuously, win_len=1, one pair (0,255) per RUN -> windows repeat every 3 cycles (IDLE,RUN,DONE); lt=1, max_val=255 each window; start in RUN/DONE ignored.
REQ-038 Random bench, 1000 windows, M=12: scoreboard checks REQ-019/020/024 against reference compare each transfer.
